// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pkg
//  Purpose  : Shared types and helpers for the memory read-port arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

   // Arbiter sequencing: accept a request, wait out the read latency, respond.
   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_WAIT = 2'd1,
      ARB_RESP = 2'd2
   } arb_state_t;

   // Which requester owns the current (or most recent) access.
   typedef enum logic {
      OWN_FETCH = 1'b0,
      OWN_DATA  = 1'b1
   } arb_owner_t;

   // Data width in bits for a burst of 2**extra bytes.
   function automatic int mem_arb_dw(input int extra);
      return (2 ** extra) * 8;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick2
//  Purpose  : Two-way round-robin pick. Bit 0 = fetch, bit 1 = data.
//             On contention the requester that did not own last wins.
//  Revision : 1.0  initial release
// ============================================================================
module rr_pick2
   import mem_arb_pkg::*;
(
   input  logic [1:0]  req,
   input  arb_owner_t  last_owner,
   output logic [1:0]  gnt
);

   // One-hot pick; contention is resolved away from the previous owner.
   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (last_owner == OWN_DATA) ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one memory read port between instruction fetch and data
//             load. Round-robin, one access in flight; fixed read latency;
//             results returned with a one-cycle valid pulse to the winner.
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW      = 4,
   parameter int EXTRA   = 4,
   parameter int LATENCY = 1,
   localparam int DW     = mem_arb_dw(EXTRA)
)(
   input  logic             clk,
   input  logic             reset,

   input  logic             f_req,
   input  logic [AW:0]      f_addr,
   input  logic [EXTRA-1:0] f_extra,
   input  logic [AW:0]      f_lower,
   input  logic [AW:0]      f_upper,
   output logic             f_gnt,
   output logic             f_valid,
   output logic [DW-1:0]    f_data,
   output logic             f_error,

   input  logic             d_req,
   input  logic [AW:0]      d_addr,
   input  logic [EXTRA-1:0] d_extra,
   input  logic [AW:0]      d_lower,
   input  logic [AW:0]      d_upper,
   output logic             d_gnt,
   output logic             d_valid,
   output logic [DW-1:0]    d_data,
   output logic             d_error,

   output logic [AW:0]      mem_addr,
   output logic [EXTRA-1:0] mem_extra,
   output logic [AW:0]      mem_lower_bound,
   output logic [AW:0]      mem_upper_bound,
   input  logic [DW-1:0]    mem_data,
   input  logic             mem_error,

   output logic             busy
);

   localparam int CW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

   arb_state_t r_state;
   arb_state_t w_next_state;
   arb_owner_t r_owner;
   arb_owner_t r_last_owner;
   logic [CW-1:0] r_cnt;
   logic [1:0]    w_pick;
   logic          w_grant;

   rr_pick2 u_pick (
      .req        ({d_req, f_req}),
      .last_owner (r_last_owner),
      .gnt        (w_pick)
   );

   assign w_grant = f_gnt | d_gnt;
   assign busy    = (r_state != ARB_IDLE);

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ARB_IDLE;
      else       r_state <= w_next_state;
   end

   // Next state plus grant/valid pulses; grants are masked while reset is held.
   always_comb begin
      w_next_state = r_state;
      f_gnt        = 1'b0;
      d_gnt        = 1'b0;
      f_valid      = 1'b0;
      d_valid      = 1'b0;
      case (r_state)
         ARB_IDLE: begin
            if (!reset && (w_pick != 2'b00)) begin
               f_gnt        = w_pick[0];
               d_gnt        = w_pick[1];
               w_next_state = ARB_WAIT;
            end
         end
         ARB_WAIT: begin
            if (r_cnt == '0) w_next_state = ARB_RESP;
         end
         ARB_RESP: begin
            f_valid      = (r_owner == OWN_FETCH);
            d_valid      = (r_owner == OWN_DATA);
            w_next_state = ARB_IDLE;
         end
         default: w_next_state = ARB_IDLE;
      endcase
   end

   // Request latch onto the memory port, latency counter and ownership.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_addr        <= '0;
         mem_extra       <= '0;
         mem_lower_bound <= '0;
         mem_upper_bound <= '1;
         r_owner         <= OWN_FETCH;
         r_last_owner    <= OWN_DATA;
         r_cnt           <= '0;
      end else begin
         if (w_grant) begin
            r_cnt <= CW'(LATENCY);
            if (f_gnt) begin
               r_owner         <= OWN_FETCH;
               mem_addr        <= f_addr;
               mem_extra       <= f_extra;
               mem_lower_bound <= f_lower;
               mem_upper_bound <= f_upper;
            end else begin
               r_owner         <= OWN_DATA;
               mem_addr        <= d_addr;
               mem_extra       <= d_extra;
               mem_lower_bound <= d_lower;
               mem_upper_bound <= d_upper;
            end
         end else if (r_state == ARB_WAIT && r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
         end
         if (r_state == ARB_RESP) r_last_owner <= r_owner;
      end
   end

   // Capture the memory response into the owner's result registers only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         f_data  <= '0;
         f_error <= 1'b0;
         d_data  <= '0;
         d_error <= 1'b0;
      end else if (r_state == ARB_WAIT && r_cnt == '0) begin
         if (r_owner == OWN_FETCH) begin
            f_data  <= mem_data;
            f_error <= mem_error;
         end else begin
            d_data  <= mem_data;
            d_error <= mem_error;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Self-checking bench for mem_port_arbiter with a byte[i]=i ROM.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

   localparam int AW      = 4;
   localparam int EXTRA   = 4;
   localparam int LATENCY = 1;
   localparam int DW      = 128;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic f_req = 1'b0, d_req = 1'b0;
   logic [AW:0] f_addr = '0, f_lower = '0, f_upper = '1;
   logic [AW:0] d_addr = '0, d_lower = '0, d_upper = '1;
   logic [EXTRA-1:0] f_extra = '0, d_extra = '0;
   logic f_gnt, f_valid, f_error, d_gnt, d_valid, d_error, busy;
   logic [DW-1:0] f_data, d_data;
   logic [AW:0] mem_addr, mem_lower_bound, mem_upper_bound;
   logic [EXTRA-1:0] mem_extra;
   logic [DW-1:0] rom_data;
   logic rom_err;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.AW(AW), .EXTRA(EXTRA), .LATENCY(LATENCY)) dut (
      .clk(clk), .reset(reset),
      .f_req(f_req), .f_addr(f_addr), .f_extra(f_extra), .f_lower(f_lower), .f_upper(f_upper),
      .f_gnt(f_gnt), .f_valid(f_valid), .f_data(f_data), .f_error(f_error),
      .d_req(d_req), .d_addr(d_addr), .d_extra(d_extra), .d_lower(d_lower), .d_upper(d_upper),
      .d_gnt(d_gnt), .d_valid(d_valid), .d_data(d_data), .d_error(d_error),
      .mem_addr(mem_addr), .mem_extra(mem_extra), .mem_lower_bound(mem_lower_bound),
      .mem_upper_bound(mem_upper_bound), .mem_data(rom_data), .mem_error(rom_err),
      .busy(busy)
   );

   function automatic logic [DW-1:0] rom_word(input logic [AW:0] a);
      logic [DW-1:0] w;
      for (int k = 0; k < DW / 8; k++) w[k*8 +: 8] = 8'(int'(a) + k);
      return w;
   endfunction

   // Behavioural genrom: one-cycle read latency, out-of-bounds flagged.
   always_ff @(posedge clk) begin
      rom_data <= rom_word(mem_addr);
      rom_err  <= (mem_addr < mem_lower_bound) || (mem_addr > mem_upper_bound);
   end

   // Transaction-level reference model state.
   int cyc = 0, vcyc = 0;
   bit have_txn = 0, own = 0, last_own = 1, fg_seen = 0, dg_seen = 0, auto_drop = 1;
   logic [DW-1:0] txn_data = '0, exp_fd = '0, exp_dd = '0;
   bit txn_err = 0, exp_fe = 0, exp_de = 0;
   logic [AW:0] m_addr = '0, m_lo = '0, m_hi = '1;
   logic [EXTRA-1:0] m_extra = '0;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic check();
      bit resp, idle, efg, edg;
      cyc++;
      if (reset) begin
         have_txn = 0; last_own = 1; exp_fd = '0; exp_dd = '0; exp_fe = 0; exp_de = 0;
         m_addr = '0; m_lo = '0; m_hi = '1; m_extra = '0;
         efg = 0; edg = 0;
      end else begin
         resp = have_txn && (cyc == vcyc);
         if (resp) begin
            if (!own) begin exp_fd = txn_data; exp_fe = txn_err; end
            else      begin exp_dd = txn_data; exp_de = txn_err; end
         end
         idle = !have_txn;
         efg  = idle && f_req && (!d_req || last_own);
         edg  = idle && d_req && (!f_req || !last_own);
         chk("f_valid", f_valid, resp && !own);
         chk("d_valid", d_valid, resp && own);
      end
      chk("f_gnt",   f_gnt,   efg);
      chk("d_gnt",   d_gnt,   edg);
      chk("busy",    busy,    !reset && have_txn);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_extra", mem_extra, m_extra);
      chk("mem_lower", mem_lower_bound, m_lo);
      chk("mem_upper", mem_upper_bound, m_hi);
      chk("f_data",  f_data,  exp_fd);
      chk("f_error", f_error, exp_fe);
      chk("d_data",  d_data,  exp_dd);
      chk("d_error", d_error, exp_de);
      if (reset) begin
         chk("f_valid_rst", f_valid, 1'b0);
         chk("d_valid_rst", d_valid, 1'b0);
      end else begin
         if (have_txn && cyc == vcyc) begin have_txn = 0; last_own = own; end
         if (efg || edg) begin
            have_txn = 1; own = edg; vcyc = cyc + LATENCY + 2;
            m_addr  = efg ? f_addr  : d_addr;
            m_extra = efg ? f_extra : d_extra;
            m_lo    = efg ? f_lower : d_lower;
            m_hi    = efg ? f_upper : d_upper;
            txn_data = rom_word(m_addr);
            txn_err  = (m_addr < m_lo) || (m_addr > m_hi);
         end
      end
      fg_seen = efg; dg_seen = edg;
   endtask

   // One clock: check just after the falling edge, then step to the next one.
   task automatic tick();
      #1 check();
      @(posedge clk);
      @(negedge clk);
      if (auto_drop && fg_seen) f_req = 1'b0;
      if (auto_drop && dg_seen) d_req = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      // Reset state
      repeat (2) tick();
      reset = 1'b0;
      tick();

      // 1: single fetch from address 0
      f_req = 1; f_addr = 0; f_lower = 0; f_upper = '1; f_extra = 4'h3;
      repeat (5) tick();
      chk("t1_f_data", f_data, 128'h0f0e0d0c0b0a09080706050403020100);
      chk("t1_f_error", f_error, 1'b0);

      // 2: simultaneous requests from reset; fetch first
      reset = 1; tick(); reset = 0;
      f_req = 1; f_addr = 5'd2; d_req = 1; d_addr = 5'd7; d_lower = 0; d_upper = '1;
      repeat (10) tick();
      chk("t2_f_data", f_data, rom_word(5'd2));
      chk("t2_d_data", d_data, rom_word(5'd7));

      // 3: both held continuously; grants alternate
      auto_drop = 0;
      f_req = 1; d_req = 1; f_addr = 5'd1; d_addr = 5'd9;
      repeat (16) tick();
      f_req = 0; d_req = 0; auto_drop = 1;
      repeat (4) tick();

      // 4: data load outside bounds reports error
      d_req = 1; d_addr = 5'd4; d_lower = 5'd0; d_upper = 5'd3; d_extra = 4'ha;
      repeat (5) tick();
      chk("t4_d_error", d_error, 1'b1);

      // 5: reset in the middle of the wait
      f_req = 1; f_addr = 5'd6; f_upper = '1;
      tick(); tick();
      reset = 1; tick();
      chk("t5_upper_rst", mem_upper_bound, 5'h1f);
      reset = 0; tick();
      f_req = 1; f_addr = 5'd3;
      repeat (5) tick();
      chk("t5_f_data", f_data, rom_word(5'd3));

      // 6: data request pulsed while busy and dropped
      f_req = 1; f_addr = 5'd8;
      tick();
      d_req = 1; d_addr = 5'd5; tick();
      d_req = 0;
      repeat (6) tick();
      chk("t6_d_data", d_data, '0);

      // Randomized traffic
      d_upper = '1;
      for (int i = 0; i < 400; i++) begin
         if (!f_req && ($urandom % 3 == 0)) f_req = 1;
         else if (f_req && ($urandom % 20 == 0)) f_req = 0;
         if (!d_req && ($urandom % 3 == 0)) d_req = 1;
         else if (d_req && ($urandom % 20 == 0)) d_req = 0;
         f_addr = 5'($urandom); f_lower = 5'($urandom); f_upper = 5'($urandom); f_extra = 4'($urandom);
         d_addr = 5'($urandom); d_lower = 5'($urandom); d_upper = 5'($urandom); d_extra = 4'($urandom);
         if ($urandom % 150 == 0) reset = 1;
         tick();
         reset = 0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
